fp_addsub_seq: RTL and testbench

- Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor for the custom-instruction datapath.
- Widths come from EXP_W/MAN_W, so one block covers binary32 and binary16.
- Adds an explicit add/sub opcode, round-to-nearest-even, special-value handling (Inf/NaN/signed zero) and exception flags.
- Normalisation is sequential (one left shift per cycle), so latency depends on the data.

---
 rtl/fp_pkg.sv | 73 +++++++
 rtl/fp_round_rne.sv | 70 +++++++
 rtl/fp_addsub_seq.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared types and helpers for the sequential floating-point
//                add/sub unit and its rounding stage. This covers the default
//                format widths, the FSM state encoding, operand classification,
//                and the exponent-constant and canonical-qNaN builders.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int c_EXP_W_DEF  = 8;
    localparam int c_MAN_W_DEF  = 23;
    localparam int c_QNAN_MAX_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_ROUND = 3'd4
    } fp_state_e;

    typedef enum logic [1:0] {
        FP_ZERO   = 2'd0,
        FP_INF    = 2'd1,
        FP_NAN    = 2'd2,
        FP_NORMAL = 2'd3
    } fp_class_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_emax(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Working exponent width: room for the carry increment and for up to
    // MAN_W+3 normalisation decrements below exponent 1, plus a sign bit.
    function automatic int fp_exp_calc_w(input int exp_w, input int man_w);
        return exp_w + $clog2(man_w + 4) + 2;
    endfunction

    // Canonical quiet NaN, right-aligned in a 64-bit word; callers slice the
    // low 1+exp_w+man_w bits.
    function automatic logic [c_QNAN_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [c_QNAN_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

    // Denormals (exponent 0) are classified as zero: the unit flushes them.
    function automatic fp_class_e fp_classify(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic man_zero);
        fp_class_e cls;
        if (exp_zero) begin
            cls = FP_ZERO;
        end else if (exp_ones) begin
            cls = man_zero ? FP_INF : FP_NAN;
        end else begin
            cls = FP_NORMAL;
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round_rne
//  Description : Combinational round-to-nearest-even on a normalised
//                significand with guard/round/sticky bits. It adjusts the
//                exponent on mantissa carry-out, packs the result and detects
//                overflow (-> signed Inf) and underflow (-> signed zero).
//  Ports       : i_sign    result sign
//                i_exp     signed working exponent (biased)
//                i_frac    {mantissa[MAN_W-1:0], G, R, S} (hidden bit implied)
//                o_result  packed {sign, exponent, mantissa}
//                o_ovf     exponent reached all-ones after rounding
//                o_unf     exponent at or below zero after rounding
//  Revision    : 1.0  initial release
// ============================================================================
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int EXP_W = c_EXP_W_DEF,
    parameter int MAN_W = c_MAN_W_DEF,
    localparam int c_W  = 1 + EXP_W + MAN_W,
    localparam int c_EW = fp_exp_calc_w(EXP_W, MAN_W)
) (
    input  logic                   i_sign,
    input  logic signed [c_EW-1:0] i_exp,
    input  logic [MAN_W+2:0]       i_frac,
    output logic [c_W-1:0]         o_result,
    output logic                   o_ovf,
    output logic                   o_unf
);

    localparam logic signed [c_EW-1:0] c_ONE    = c_EW'(1);
    localparam logic signed [c_EW-1:0] c_ZERO   = '0;
    localparam logic signed [c_EW-1:0] c_EMAX_S = c_EW'(fp_emax(EXP_W));

    logic                   w_lsb;
    logic                   w_guard;
    logic                   w_round;
    logic                   w_sticky;
    logic                   w_round_up;
    logic [MAN_W:0]         w_man_inc;
    logic                   w_carry;
    logic signed [c_EW-1:0] w_exp_rnd;

    assign w_lsb      = i_frac[3];
    assign w_guard    = i_frac[2];
    assign w_round    = i_frac[1];
    assign w_sticky   = i_frac[0];
    // Round up above half-way, or exactly half-way when the LSB is odd.
    assign w_round_up = w_guard & (w_round | w_sticky | w_lsb);
    assign w_man_inc  = {1'b0, i_frac[MAN_W+2:3]} + {{MAN_W{1'b0}}, w_round_up};
    assign w_carry    = w_man_inc[MAN_W];
    // On carry the mantissa wraps to zero and the significand becomes 10.0..0.
    assign w_exp_rnd  = i_exp + (w_carry ? c_ONE : c_ZERO);

    always_comb begin
        o_ovf    = 1'b0;
        o_unf    = 1'b0;
        o_result = {i_sign, w_exp_rnd[EXP_W-1:0], w_man_inc[MAN_W-1:0]};
        if (w_exp_rnd >= c_EMAX_S) begin
            o_ovf    = 1'b1;
            o_result = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_exp_rnd <= c_ZERO) begin
            o_unf    = 1'b1;
            o_result = {i_sign, {(c_W-1){1'b0}}};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_addsub_seq
//  Description : Multi-cycle floating-point adder/subtractor with
//                round-to-nearest-even, flush-to-zero of denormals,
//                Inf/NaN/signed-zero handling and exception flags.
//                Normalisation shifts left one bit per cycle, so the latency
//                is 4 + L cycles, where L is the number of left shifts.
//  Ports       : clk, reset_n  clock, synchronous active-low reset
//                enable        start request (sampled in IDLE only)
//                op_sub        1: dataa - datab
//                dataa, datab  operands
//                result        registered result, held until next done
//                done          one-cycle result-valid pulse
//                busy          operation in flight
//                flag_ovf/unf/inv  exception flags, valid with done, held
//  Revision    : 1.0  initial release
// ============================================================================
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = c_EXP_W_DEF,
    parameter int MAN_W = c_MAN_W_DEF,
    localparam int c_W  = 1 + EXP_W + MAN_W
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           enable,
    input  logic           op_sub,
    input  logic [c_W-1:0] dataa,
    input  logic [c_W-1:0] datab,
    output logic [c_W-1:0] result,
    output logic           done,
    output logic           busy,
    output logic           flag_ovf,
    output logic           flag_unf,
    output logic           flag_inv
);

    localparam int c_SW = MAN_W + 4;  // hidden + mantissa + G/R/S
    localparam int c_EW = fp_exp_calc_w(EXP_W, MAN_W);
    localparam logic [c_QNAN_MAX_W-1:0] c_QNAN_FULL = fp_qnan(EXP_W, MAN_W);
    localparam logic [c_W-1:0]          c_QNAN      = c_QNAN_FULL[c_W-1:0];
    localparam logic [EXP_W-1:0]        c_EXP_ONES  = '1;
    localparam logic [31:0]             c_DIFF_MAX  = 32'(c_SW - 1);
    localparam logic signed [c_EW-1:0]  c_EXP_ONE   = c_EW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fp_state_e              state_q,       state_d;
    logic [c_W-1:0]         a_q,           a_d;
    logic [c_W-1:0]         b_q,           b_d;
    logic                   sign_q,        sign_d;
    logic signed [c_EW-1:0] exp_q,         exp_d;
    logic [c_SW-1:0]        big_q,         big_d;
    logic [c_SW-1:0]        small_q,       small_d;
    logic                   eff_sub_q,     eff_sub_d;
    logic                   special_q,     special_d;
    logic [c_W-1:0]         spec_res_q,    spec_res_d;
    logic                   spec_inv_q,    spec_inv_d;
    logic [c_SW:0]          sum_q,         sum_d;
    logic [c_W-1:0]         result_q,      result_d;
    logic                   done_q,        done_d;
    logic                   busy_q,        busy_d;
    logic                   ovf_q,         ovf_d;
    logic                   unf_q,         unf_d;
    logic                   inv_q,         inv_d;

    // ------------------------------------------------------------------
    // Operand classification, swap and alignment (used in ALIGN)
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] w_a_exp, w_b_exp, w_big_exp, w_small_exp, w_diff;
    logic [MAN_W-1:0] w_a_man, w_b_man, w_big_man, w_small_man;
    logic             w_a_sign, w_b_sign, w_swap;
    fp_class_e        w_a_cls, w_b_cls;
    logic [c_SW-1:0]  w_small_sig, w_shifted, w_lost_mask, w_aligned;
    logic             w_sticky;
    logic [31:0]      w_diff_32;
    logic             w_special;
    logic [c_W-1:0]   w_spec_res;
    logic             w_spec_inv;

    assign w_a_sign = a_q[c_W-1];
    assign w_b_sign = b_q[c_W-1];
    assign w_a_exp  = a_q[c_W-2:MAN_W];
    assign w_b_exp  = b_q[c_W-2:MAN_W];
    assign w_a_man  = a_q[MAN_W-1:0];
    assign w_b_man  = b_q[MAN_W-1:0];
    assign w_a_cls  = fp_classify(w_a_exp == '0, w_a_exp == c_EXP_ONES, w_a_man == '0);
    assign w_b_cls  = fp_classify(w_b_exp == '0, w_b_exp == c_EXP_ONES, w_b_man == '0);

    // Magnitude compare on {exponent, mantissa} orders the operands.
    assign w_swap      = b_q[c_W-2:0] > a_q[c_W-2:0];
    assign w_big_exp   = w_swap ? w_b_exp : w_a_exp;
    assign w_big_man   = w_swap ? w_b_man : w_a_man;
    assign w_small_exp = w_swap ? w_a_exp : w_b_exp;
    assign w_small_man = w_swap ? w_a_man : w_b_man;
    assign w_diff      = w_big_exp - w_small_exp;
    assign w_diff_32   = 32'(w_diff);

    assign w_small_sig = {1'b1, w_small_man, 3'b000};
    assign w_shifted   = w_small_sig >> w_diff;
    assign w_lost_mask = ~({c_SW{1'b1}} << w_diff);
    assign w_sticky    = |(w_small_sig & w_lost_mask);
    // Beyond the datapath width only the (always set) sticky survives.
    assign w_aligned   = (w_diff_32 > c_DIFF_MAX) ? {{(c_SW-1){1'b0}}, 1'b1}
                                                  : (w_shifted | {{(c_SW-1){1'b0}}, w_sticky});

    always_comb begin
        w_special  = 1'b1;
        w_spec_inv = 1'b0;
        w_spec_res = a_q;
        if (w_a_cls == FP_NAN || w_b_cls == FP_NAN) begin
            w_spec_res = c_QNAN;
        end else if (w_a_cls == FP_INF && w_b_cls == FP_INF) begin
            if (w_a_sign != w_b_sign) begin
                w_spec_res = c_QNAN;
                w_spec_inv = 1'b1;
            end else begin
                w_spec_res = a_q;
            end
        end else if (w_a_cls == FP_INF) begin
            w_spec_res = a_q;
        end else if (w_b_cls == FP_INF) begin
            w_spec_res = b_q;
        end else if (w_a_cls == FP_ZERO && w_b_cls == FP_ZERO) begin
            // Only -0 + -0 keeps the negative sign.
            w_spec_res = {w_a_sign & w_b_sign, {(c_W-1){1'b0}}};
        end else if (w_a_cls == FP_ZERO) begin
            w_spec_res = b_q;
        end else if (w_b_cls == FP_ZERO) begin
            w_spec_res = a_q;
        end else begin
            w_special = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Rounding / packing
    // ------------------------------------------------------------------
    logic [c_W-1:0] w_rnd_result;
    logic           w_rnd_ovf;
    logic           w_rnd_unf;

    fp_round_rne #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .i_sign   (sign_q),
        .i_exp    (exp_q),
        .i_frac   (sum_q[c_SW-2:0]),
        .o_result (w_rnd_result),
        .o_ovf    (w_rnd_ovf),
        .o_unf    (w_rnd_unf)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        big_d      = big_q;
        small_d    = small_q;
        eff_sub_d  = eff_sub_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        spec_inv_d = spec_inv_q;
        sum_d      = sum_q;
        result_d   = result_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        inv_d      = inv_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    a_d     = dataa;
                    b_d     = {datab[c_W-1] ^ op_sub, datab[c_W-2:0]};
                    busy_d  = 1'b1;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    inv_d   = 1'b0;
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                sign_d     = w_swap ? w_b_sign : w_a_sign;
                exp_d      = c_EW'(w_big_exp);
                big_d      = {1'b1, w_big_man, 3'b000};
                small_d    = w_aligned;
                eff_sub_d  = w_a_sign ^ w_b_sign;
                special_d  = w_special;
                spec_res_d = w_spec_res;
                spec_inv_d = w_spec_inv;
                state_d    = ST_ADD;
            end
            ST_ADD: begin
                if (eff_sub_q) begin
                    sum_d = {1'b0, big_q} - {1'b0, small_q};
                end else begin
                    sum_d = {1'b0, big_q} + {1'b0, small_q};
                end
                state_d = ST_NORM;
            end
            ST_NORM: begin
                if (special_q) begin
                    state_d = ST_ROUND;
                end else if (sum_q[c_SW]) begin
                    // Carry out: fold the dropped LSB into sticky.
                    sum_d   = {1'b0, sum_q[c_SW:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + c_EXP_ONE;
                    state_d = ST_ROUND;
                end else if (sum_q[c_SW-1] || sum_q == '0) begin
                    state_d = ST_ROUND;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - c_EXP_ONE;
                end
            end
            ST_ROUND: begin
                if (special_q) begin
                    result_d = spec_res_q;
                    inv_d    = spec_inv_q;
                end else if (sum_q == '0) begin
                    result_d = '0;
                end else begin
                    result_d = w_rnd_result;
                    ovf_d    = w_rnd_ovf;
                    unf_d    = w_rnd_unf;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            big_q      <= '0;
            small_q    <= '0;
            eff_sub_q  <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            spec_inv_q <= 1'b0;
            sum_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            big_q      <= big_d;
            small_q    <= small_d;
            eff_sub_q  <= eff_sub_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            spec_inv_q <= spec_inv_d;
            sum_q      <= sum_d;
            result_q   <= result_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            inv_q      <= inv_d;
        end
    end

    assign result   = result_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign flag_ovf = ovf_q;
    assign flag_unf = unf_q;
    assign flag_inv = inv_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_addsub_seq
//  Description : Directed self-checking bench for fp_addsub_seq in binary32
//                and binary16 configurations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_addsub_seq;

    logic        clk;
    logic        reset_n;
    logic        enable,  h_enable;
    logic        op_sub,  h_op_sub;
    logic [31:0] dataa,   datab,   result;
    logic [15:0] h_dataa, h_datab, h_result;
    logic        done,  busy,  flag_ovf,  flag_unf,  flag_inv;
    logic        h_done, h_busy, h_flag_ovf, h_flag_unf, h_flag_inv;

    int n_cmp;
    int n_fail;
    int pulses;
    int first;

    fp_addsub_seq u_dut32 (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .op_sub   (op_sub),
        .dataa    (dataa),
        .datab    (datab),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .flag_ovf (flag_ovf),
        .flag_unf (flag_unf),
        .flag_inv (flag_inv)
    );

    fp_addsub_seq #(
        .EXP_W (5),
        .MAN_W (10)
    ) u_dut16 (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (h_enable),
        .op_sub   (h_op_sub),
        .dataa    (h_dataa),
        .datab    (h_datab),
        .result   (h_result),
        .done     (h_done),
        .busy     (h_busy),
        .flag_ovf (h_flag_ovf),
        .flag_unf (h_flag_unf),
        .flag_inv (h_flag_inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Launch one operation on the selected instance and check latency,
    // result, flags {ovf,unf,inv} and that done is a single pulse.
    task automatic run_op(input string tag, input bit half,
                          input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] exp_res, input logic [2:0] exp_flags,
                          input int exp_lat);
        int cyc;
        bit seen;
        @(negedge clk);
        if (half) begin
            h_dataa = a[15:0]; h_datab = b[15:0]; h_op_sub = sub; h_enable = 1'b1;
        end else begin
            dataa = a; datab = b; op_sub = sub; enable = 1'b1;
        end
        @(posedge clk);
        #1;
        enable   = 1'b0;
        h_enable = 1'b0;
        check({tag, "_busy"}, 64'(half ? h_busy : busy), 64'(1));
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = half ? h_done : done;
        end
        check({tag, "_done"}, 64'(seen), 64'(1));
        check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_res"}, half ? 64'(h_result) : 64'(result), 64'(exp_res));
        check({tag, "_flags"},
              half ? 64'({h_flag_ovf, h_flag_unf, h_flag_inv}) : 64'({flag_ovf, flag_unf, flag_inv}),
              64'(exp_flags));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, half ? 64'({h_done, h_busy}) : 64'({done, busy}), 64'(0));
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        enable   = 1'b0;
        op_sub   = 1'b0;
        dataa    = '0;
        datab    = '0;
        h_enable = 1'b0;
        h_op_sub = 1'b0;
        h_dataa  = '0;
        h_datab  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst32", 64'({result, done, busy, flag_ovf, flag_unf, flag_inv}), 64'(0));
        check("rst16", 64'({h_result, h_done, h_busy, h_flag_ovf, h_flag_unf, h_flag_inv}), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Main function, binary32
        run_op("add_1_2",    1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 4);
        run_op("sub_ulp",    1'b0, 32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000, 28);
        run_op("sub_cancel", 1'b0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 4);
        run_op("rne_tie",    1'b0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000, 4);
        run_op("rne_up",     1'b0, 32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000, 4);
        run_op("ovf",        1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100, 4);
        run_op("inf_m_inf",  1'b0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001, 4);
        // Signed zeros, zero operand, NaN, Inf, underflow
        run_op("pz_nz",      1'b0, 32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000, 4);
        run_op("nz_nz",      1'b0, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000, 4);
        run_op("x_plus_0",   1'b0, 32'hC0490FDB, 32'h00000000, 1'b0, 32'hC0490FDB, 3'b000, 4);
        run_op("nan_in",     1'b0, 32'h3F800000, 32'hFFC12345, 1'b0, 32'h7FC00000, 3'b000, 4);
        run_op("inf_p_fin",  1'b0, 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000, 4);
        run_op("unf",        1'b0, 32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 3'b010, 5);
        run_op("neg_sum",    1'b0, 32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000, 5);
        // binary16 configuration
        run_op("h_add",      1'b1, 32'h3C00, 32'h3C00, 1'b0, 32'h4000, 3'b000, 4);
        run_op("h_ovf",      1'b1, 32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 3'b100, 4);

        // enable re-pulsed while busy must be ignored
        @(negedge clk);
        dataa = 32'h3F800000; datab = 32'h3F7FFFFF; op_sub = 1'b1; enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 3) begin
                dataa = 32'h40000000; datab = 32'h40000000; op_sub = 1'b0; enable = 1'b1;
            end
            if (i == 5) enable = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        check("busy_en_pulses", 64'(pulses), 64'(1));
        check("busy_en_lat", 64'(first), 64'(28));
        check("busy_en_res", 64'(result), 64'(32'h33800000));

        // Reset during NORM aborts the operation
        @(negedge clk);
        dataa = 32'h3F800000; datab = 32'h3F7FFFFF; op_sub = 1'b1; enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid", 64'({result, done, busy}), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        check("rst_mid_quiet", 64'(pulses), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
